mac_conv_sequencer: RTL and testbench

- Sequences the single 8x8-bit MAC unit (12-bit accumulator) through a 2-D valid-mode convolution of an IMG_H x IMG_W image with an FILT_H x FILT_W filter.
- Generates image and filter memory read addresses and drives the MAC's accumulator clear and enable.
- Captures each 12-bit window sum and presents it on a valid/ready output stream with its output coordinates.
- Sits between the image/filter memories, the MAC, and the result writer.

---
 rtl/mac_conv_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_mac_conv_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_conv_sequencer.sv
// mac_conv_sequencer: walks one 8x8-bit MAC through a valid-mode 2-D convolution.
// Generates image/filter read addresses, sequences accumulator clear/enable and
// hands each window sum to a valid/ready result stream with its coordinates.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start, busy low
// CLR    | accumulator clear, tap 0 addresses presented
// MAC    | taps 1..N-1 presented, previous tap's data accumulated
// DRAIN  | last tap's data accumulated, no new address
// OUT    | result offered; held until out_ready
// FIN    | done pulse after the final result is accepted
module mac_conv_sequencer #(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int FILT_W  = 3,
  parameter int FILT_H  = 3,
  parameter int IMG_AW  = 6,
  parameter int FILT_AW = 4,
  parameter int POS_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [IMG_AW-1:0]  img_addr,
  output logic [FILT_AW-1:0] filt_addr,
  output logic               mac_rst_acc,
  output logic               mac_acc_en,
  input  logic [11:0]        mac_out,
  output logic [11:0]        out_data,
  output logic [POS_W-1:0]   out_row,
  output logic [POS_W-1:0]   out_col,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  localparam logic [POS_W-1:0] ROW_LAST = POS_W'(IMG_H - FILT_H);
  localparam logic [POS_W-1:0] COL_LAST = POS_W'(IMG_W - FILT_W);
  localparam logic [POS_W-1:0] FR_LAST  = POS_W'(FILT_H - 1);
  localparam logic [POS_W-1:0] FC_LAST  = POS_W'(FILT_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_MAC,
    S_DRAIN,
    S_OUT,
    S_FIN
  } state_t;

  state_t             state;
  logic [POS_W-1:0]   row;
  logic [POS_W-1:0]   col;
  logic [POS_W-1:0]   fr;
  logic [POS_W-1:0]   fc;
  logic [POS_W-1:0]   fr_nx;
  logic [POS_W-1:0]   fc_nx;
  logic [POS_W-1:0]   row_nx;
  logic [POS_W-1:0]   col_nx;
  logic               tap_last;
  logic               win_last;
  logic [11:0]        cap_q;
  logic               first_q;

  function automatic logic [IMG_AW-1:0] img_index(input logic [POS_W-1:0] r,
                                                   input logic [POS_W-1:0] c,
                                                   input logic [POS_W-1:0] tr,
                                                   input logic [POS_W-1:0] tc);
    int idx;
    idx = (int'(r) + int'(tr)) * IMG_W + int'(c) + int'(tc);
    return IMG_AW'(idx);
  endfunction

  function automatic logic [FILT_AW-1:0] filt_index(input logic [POS_W-1:0] tr,
                                                    input logic [POS_W-1:0] tc);
    int idx;
    idx = int'(tr) * FILT_W + int'(tc);
    return FILT_AW'(idx);
  endfunction

  // Next tap and next window position, both row-major.
  always_comb begin
    tap_last = (fr == FR_LAST) && (fc == FC_LAST);
    fr_nx    = fr;
    fc_nx    = fc + 1'b1;
    if (fc == FC_LAST) begin
      fc_nx = '0;
      fr_nx = fr + 1'b1;
    end
    win_last = (row == ROW_LAST) && (col == COL_LAST);
    row_nx   = row;
    col_nx   = col + 1'b1;
    if (col == COL_LAST) begin
      col_nx = '0;
      row_nx = row + 1'b1;
    end
  end

  // The final tap only lands in the accumulator at the end of DRAIN, so on the
  // first OUT cycle the live MAC value is forwarded; it is frozen in cap_q after.
  assign out_data = first_q ? mac_out : cap_q;

  // Sequencer state, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      row         <= '0;
      col         <= '0;
      fr          <= '0;
      fc          <= '0;
      img_addr    <= '0;
      filt_addr   <= '0;
      mac_rst_acc <= 1'b0;
      mac_acc_en  <= 1'b0;
      out_row     <= '0;
      out_col     <= '0;
      out_valid   <= 1'b0;
      cap_q       <= '0;
      first_q     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      mac_rst_acc <= 1'b0;
      mac_acc_en  <= 1'b0;
      done        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_CLR;
            busy        <= 1'b1;
            row         <= '0;
            col         <= '0;
            fr          <= '0;
            fc          <= '0;
            img_addr    <= '0;
            filt_addr   <= '0;
            mac_rst_acc <= 1'b1;
          end
        end
        S_CLR, S_MAC: begin
          mac_acc_en <= 1'b1;
          if (tap_last) begin
            state <= S_DRAIN;
          end else begin
            state     <= S_MAC;
            fr        <= fr_nx;
            fc        <= fc_nx;
            img_addr  <= img_index(row, col, fr_nx, fc_nx);
            filt_addr <= filt_index(fr_nx, fc_nx);
          end
        end
        S_DRAIN: begin
          state     <= S_OUT;
          out_valid <= 1'b1;
          first_q   <= 1'b1;
          out_row   <= row;
          out_col   <= col;
        end
        S_OUT: begin
          first_q <= 1'b0;
          if (first_q) begin
            cap_q <= mac_out;
          end
          if (out_ready) begin
            out_valid <= 1'b0;
            if (win_last) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              state       <= S_CLR;
              row         <= row_nx;
              col         <= col_nx;
              fr          <= '0;
              fc          <= '0;
              img_addr    <= img_index(row_nx, col_nx, '0, '0);
              filt_addr   <= '0;
              mac_rst_acc <= 1'b1;
            end
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_conv_sequencer.sv
// Bench for mac_conv_sequencer: memories with 1-cycle read latency and a MAC
// model around the DUT; a scoreboard queue of window sums computed directly from
// the convolution definition, popped by a monitor on each accepted result.
module tb_mac_conv_sequencer;

  localparam int IMG_W   = 8;
  localparam int IMG_H   = 8;
  localparam int FILT_W  = 3;
  localparam int FILT_H  = 3;
  localparam int IMG_AW  = 6;
  localparam int FILT_AW = 4;
  localparam int POS_W   = 4;
  localparam int N       = FILT_H * FILT_W;
  localparam int OH      = IMG_H - FILT_H + 1;
  localparam int OW      = IMG_W - FILT_W + 1;
  localparam int NW      = OH * OW;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               out_ready = 1'b0;
  logic [IMG_AW-1:0]  img_addr;
  logic [FILT_AW-1:0] filt_addr;
  logic               mac_rst_acc;
  logic               mac_acc_en;
  logic [11:0]        mac_out;
  logic [11:0]        out_data;
  logic [POS_W-1:0]   out_row;
  logic [POS_W-1:0]   out_col;
  logic               out_valid;
  logic               busy;
  logic               done;

  always #5 clk = ~clk;

  mac_conv_sequencer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .FILT_W(FILT_W), .FILT_H(FILT_H),
    .IMG_AW(IMG_AW), .FILT_AW(FILT_AW), .POS_W(POS_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .img_addr(img_addr), .filt_addr(filt_addr),
    .mac_rst_acc(mac_rst_acc), .mac_acc_en(mac_acc_en), .mac_out(mac_out),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  // Environment: synchronous-read memories feeding an 8x8 MAC with 12-bit accumulator.
  logic [7:0]  img_mem  [0:(1<<IMG_AW)-1];
  logic [7:0]  filt_mem [0:(1<<FILT_AW)-1];
  logic [7:0]  img_q = '0;
  logic [7:0]  filt_q = '0;
  logic [11:0] mac_acc = '0;

  always @(posedge clk) begin
    img_q  <= img_mem[img_addr];
    filt_q <= filt_mem[filt_addr];
    if (mac_rst_acc) mac_acc <= '0;
    else if (mac_acc_en) mac_acc <= mac_acc + 12'(16'(img_q) * 16'(filt_q));
  end
  assign mac_out = mac_acc;

  logic [34:0] all_outs;
  assign all_outs = {img_addr, filt_addr, mac_rst_acc, mac_acc_en, out_data,
                     out_row, out_col, out_valid, busy, done};

  typedef struct {
    int          r;
    int          c;
    logic [11:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   win_idx = 0;
  exp_t mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [11:0] ref_window(input int r, input int c);
    int s;
    s = 0;
    for (int i = 0; i < FILT_H; i++)
      for (int j = 0; j < FILT_W; j++)
        s += int'(img_mem[(r + i) * IMG_W + c + j]) * int'(filt_mem[i * FILT_W + j]);
    return 12'(s);
  endfunction

  task automatic push_expected();
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++)
        exp_q.push_back('{r, c, ref_window(r, c)});
  endtask

  task automatic load_ones();
    foreach (img_mem[i]) img_mem[i] = 8'd1;
    foreach (filt_mem[i]) filt_mem[i] = 8'd1;
  endtask

  task automatic load_random();
    foreach (img_mem[i]) img_mem[i] = 8'($urandom_range(0, 255));
    foreach (filt_mem[i]) filt_mem[i] = 8'($urandom_range(0, 255));
  endtask

  // Monitor: scoreboard pops, per-window start address, clear/enable exclusion, done count.
  always @(negedge clk) begin
    if (!rst) begin
      win_idx = 0;
    end else begin
      check("clr_en_exclusive", 64'(mac_rst_acc & mac_acc_en), 64'd0);
      if (mac_rst_acc) begin
        check("win_first_img_addr", 64'(img_addr), 64'((win_idx / OW) * IMG_W + win_idx % OW));
        check("win_first_filt_addr", 64'(filt_addr), 64'd0);
        win_idx = (win_idx + 1) % NW;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_result: got row=%0d col=%0d data=%0d expected none",
                   out_row, out_col, out_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("result_row", 64'(out_row), 64'(mon_e.r));
          check("result_col", 64'(out_col), 64'(mon_e.c));
          check("result_data", 64'(out_data), 64'(mon_e.d));
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Runs until done (bounded); optional random backpressure and start pulses while busy.
  task automatic wait_done(input bit rand_ready, input bit spam_start);
    int base;
    bit seen;
    base = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk); #1;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      start = spam_start && busy && ($urandom_range(0, 7) == 0);
      if (done_cnt != base) seen = 1'b1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", 64'(done_cnt - base), 64'd1);
    check("results_left", 64'(exp_q.size()), 64'd0);
    check("idle_after_frame", 64'(busy), 64'd0);
  endtask

  // All-ones frame: cycle 0 is the cycle start is high; it is sampled at the end of it.
  task automatic frame_timing();
    int  t_clr, t_en, en_len, t_valid, t_done;
    bit  en_open;
    int  addr_exp[N];
    t_clr = -1; t_en = -1; en_len = 0; t_valid = -1; t_done = -1; en_open = 1'b1;
    for (int i = 0; i < FILT_H; i++)
      for (int j = 0; j < FILT_W; j++)
        addr_exp[i * FILT_W + j] = i * IMG_W + j;
    load_ones();
    push_expected();
    out_ready = 1'b1;
    pulse_start();
    for (int cyc = 1; cyc <= 450 && t_done < 0; cyc++) begin
      @(negedge clk);
      if (mac_rst_acc && t_clr < 0) t_clr = cyc;
      if (mac_acc_en) begin
        if (t_en < 0) t_en = cyc;
        if (en_open) en_len++;
      end else if (t_en >= 0) begin
        en_open = 1'b0;
      end
      if (out_valid && t_valid < 0) begin
        t_valid = cyc;
        check("first_out_data", 64'(out_data), 64'd9);
      end
      if (cyc <= N) begin
        check("w0_img_addr", 64'(img_addr), 64'(addr_exp[cyc - 1]));
        check("w0_filt_addr", 64'(filt_addr), 64'(cyc - 1));
      end
      if (done) t_done = cyc;
    end
    check("clr_cycle", 64'(t_clr), 64'd1);
    check("acc_en_first_cycle", 64'(t_en), 64'd2);
    check("acc_en_run_length", 64'(en_len), 64'(N));
    check("first_valid_cycle", 64'(t_valid), 64'(N + 2));
    check("done_cycle", 64'(t_done), 64'(NW * (N + 2) + 1));
    repeat (3) @(posedge clk);
    #1;
    check("frameA_results_left", 64'(exp_q.size()), 64'd0);
    check("frameA_done_count", 64'(done_cnt), 64'd1);
  endtask

  // Hold the first result for 5 cycles, accept on the 6th.
  task automatic frame_backpressure();
    bit got;
    logic [11:0] s_data;
    logic [POS_W-1:0] s_row, s_col;
    logic [IMG_AW-1:0] s_img;
    logic [FILT_AW-1:0] s_filt;
    load_random();
    push_expected();
    out_ready = 1'b0;
    pulse_start();
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    check("bp_valid_seen", 64'(got), 64'd1);
    s_data = out_data; s_row = out_row; s_col = out_col; s_img = img_addr; s_filt = filt_addr;
    check("bp_first_data", 64'(s_data), 64'(ref_window(0, 0)));
    check("bp_first_pos", 64'({s_row, s_col}), 64'd0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_result", 64'({out_data, out_row, out_col}), 64'({s_data, s_row, s_col}));
      check("bp_hold_addr", 64'({img_addr, filt_addr}), 64'({s_img, s_filt}));
      check("bp_hold_acc_en", 64'(mac_acc_en), 64'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_accept_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    check("bp_next_clr", 64'({mac_rst_acc, out_valid}), 64'd2);
    wait_done(1'b1, 1'b0);
  endtask

  // Reset in the middle of a frame, then a fresh full frame.
  task automatic frame_abort();
    int base;
    load_random();
    push_expected();
    out_ready = 1'b1;
    pulse_start();
    repeat ($urandom_range(15, 60)) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("abort_outputs_zero", 64'(all_outs), 64'd0);
    exp_q.delete();
    base = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    check("abort_held_outputs_zero", 64'(all_outs), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - base), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);
    load_random();
    push_expected();
    pulse_start();
    wait_done(1'b1, 1'b1);
  endtask

  initial begin
    load_ones();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 start = ~start;
      @(negedge clk);
      check("reset_outputs_zero", 64'(all_outs), 64'd0);
    end
    @(posedge clk); #1 start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", 64'(all_outs), 64'd0);

    frame_timing();

    load_random();
    push_expected();
    pulse_start();
    wait_done(1'b1, 1'b1);

    frame_backpressure();
    frame_abort();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
